// File: rtl/sec_timer_ctrl_pkg.sv
// Shared types and constants for the seconds timer run controller.
// Holds the FSM state encoding, value width and the preset clamp helper.
package sec_timer_ctrl_pkg;

    localparam int VALUE_W = 7;
    localparam logic [VALUE_W-1:0] VALUE_MAX = 7'd99;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_PAUSE,
        ST_DONE
    } state_e;

    function automatic logic [VALUE_W-1:0] clamp_preset(
        input logic [VALUE_W-1:0] p
    );
        return (p > VALUE_MAX) ? VALUE_MAX : p;
    endfunction

endpackage

// File: rtl/sec_timer_ctrl_key_press.sv
// Active-low pushbutton to single-cycle press pulse.
// Optional stability filter enabled by SEC_TIMER_DEBOUNCE_EN.
module key_press #(
    parameter int DEBOUNCE_CYC = 500_000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic press
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic lvl_q, lvl_d;
    logic press_q, press_d;
    logic filt;

`ifdef SEC_TIMER_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYC + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic filt_q, filt_d;

    // Filtered level flips only after a run of equal differing samples
    always_comb begin
        cnt_d  = cnt_q;
        filt_d = filt_q;
        if (sync2_q == filt_q) begin
            cnt_d = '0;
        end else if (cnt_q == CW'(DEBOUNCE_CYC - 1)) begin
            cnt_d  = '0;
            filt_d = sync2_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Debounce state registers; released key level is 1
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            filt_q <= 1'b1;
        end else begin
            cnt_q  <= cnt_d;
            filt_q <= filt_d;
        end
    end

    assign filt = filt_q;
`else
    logic [31:0] dbc_unused;
    assign dbc_unused = DEBOUNCE_CYC;
    assign filt = sync2_q;
`endif

    // Synchronizer, previous-level and registered falling-edge pulse
    always_comb begin
        sync1_d = key_n;
        sync2_d = sync1_q;
        lvl_d   = filt;
        press_d = lvl_q & ~filt;
    end

    // Key path registers; reset to released so no pulse follows reset
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            lvl_q   <= 1'b1;
            press_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            lvl_q   <= lvl_d;
            press_q <= press_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/sec_timer_ctrl.sv
// Run controller for the 0-99 seconds counter with alarm and flash.
// Optional key debounce via the SEC_TIMER_DEBOUNCE_EN macro.
module sec_timer_ctrl
    import sec_timer_ctrl_pkg::*;
#(
    parameter int TICK_DIV     = 50_000_000,
    parameter int DEBOUNCE_CYC = 500_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_start,
    input  logic       key_clear,
    input  logic       sw_dir,
    input  logic [6:0] sw_preset,
    output logic [3:0] digit1,
    output logic [3:0] digit0,
    output logic       blank,
    output logic       alarm,
    output logic       running
);

    localparam int TW = $clog2(TICK_DIV);

    localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
    localparam logic [TW-1:0] FLASH_LAST = TW'(TICK_DIV / 2 - 1);

    state_e state_q, state_d;
    logic [VALUE_W-1:0] value_q, value_d;
    logic dir_q, dir_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [TW-1:0] flash_q, flash_d;
    logic blank_q, blank_d;
    logic alarm_q, alarm_d;
    logic running_q, running_d;

    logic start_p;
    logic clear_p;
    logic [VALUE_W-1:0] preset_c;
    logic term;

    key_press #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_key_start (
        .clk   (clk),
        .rst   (rst),
        .key_n (key_start),
        .press (start_p)
    );

    key_press #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_key_clear (
        .clk   (clk),
        .rst   (rst),
        .key_n (key_clear),
        .press (clear_p)
    );

    assign preset_c = clamp_preset(sw_preset);

    // Terminal test used when starting from IDLE with the live switch
    assign term = sw_dir ? (value_q >= preset_c)
                         : (value_q == '0);

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            value_q   <= '0;
            dir_q     <= 1'b0;
            tick_q    <= '0;
            flash_q   <= '0;
            blank_q   <= 1'b0;
            alarm_q   <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            value_q   <= value_d;
            dir_q     <= dir_d;
            tick_q    <= tick_d;
            flash_q   <= flash_d;
            blank_q   <= blank_d;
            alarm_q   <= alarm_d;
            running_q <= running_d;
        end
    end

    // Next state, counting, saturation and flash timing
    always_comb begin
        state_d = state_q;
        value_d = value_q;
        dir_d   = dir_q;
        tick_d  = tick_q;
        flash_d = flash_q;
        blank_d = blank_q;
        if (clear_p) begin
            state_d = ST_IDLE;
            value_d = sw_dir ? '0 : preset_c;
            tick_d  = '0;
            flash_d = '0;
            blank_d = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start_p) begin
                        dir_d   = sw_dir;
                        tick_d  = '0;
                        flash_d = '0;
                        blank_d = 1'b0;
                        state_d = term ? ST_DONE : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (start_p) begin
                        state_d = ST_PAUSE;
                    end else if (tick_q == TICK_LAST) begin
                        tick_d  = '0;
                        flash_d = '0;
                        blank_d = 1'b0;
                        if (dir_q) begin
                            if (value_q >= preset_c) begin
                                state_d = ST_DONE;
                            end else begin
                                value_d = value_q + 1'b1;
                                if (value_d == preset_c) begin
                                    state_d = ST_DONE;
                                end
                            end
                        end else begin
                            if (value_q == '0) begin
                                state_d = ST_DONE;
                            end else begin
                                value_d = value_q - 1'b1;
                                if (value_d == '0) begin
                                    state_d = ST_DONE;
                                end
                            end
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                ST_PAUSE: begin
                    if (start_p) begin
                        state_d = ST_RUN;
                    end
                end
                ST_DONE: begin
                    if (start_p) begin
                        state_d = ST_IDLE;
                        flash_d = '0;
                        blank_d = 1'b0;
                    end else if (flash_q == FLASH_LAST) begin
                        flash_d = '0;
                        blank_d = ~blank_q;
                    end else begin
                        flash_d = flash_q + 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Registered state decodes for the status outputs
    always_comb begin
        running_d = (state_d == ST_RUN);
        alarm_d   = (state_d == ST_DONE);
    end

    assign digit1  = 4'(value_q / 7'd10);
    assign digit0  = 4'(value_q % 7'd10);
    assign blank   = blank_q;
    assign alarm   = alarm_q;
    assign running = running_q;

endmodule

// File: tb/tb_sec_timer_ctrl.sv
// Directed bench for sec_timer_ctrl with TICK_DIV = 4.
// Table of key actions plus hand sequences for pause/hold/reset.
module tb_sec_timer_ctrl;

    localparam int TICK_DIV = 4;

    localparam int A_NONE  = 0;
    localparam int A_RST   = 1;
    localparam int A_START = 2;
    localparam int A_CLEAR = 3;
    localparam int A_BOTH  = 4;

    typedef struct {
        int         act;
        logic       dir;
        logic [6:0] pre;
        int         wt;
        logic [10:0] exp;
    } vec_t;

    logic       clk;
    logic       rst;
    logic       key_start;
    logic       key_clear;
    logic       sw_dir;
    logic [6:0] sw_preset;
    logic [3:0] digit1;
    logic [3:0] digit0;
    logic       blank;
    logic       alarm;
    logic       running;

    int n_cmp;
    int n_bad;
    vec_t tbl[$];

    sec_timer_ctrl #(
        .TICK_DIV     (TICK_DIV),
        .DEBOUNCE_CYC (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .key_start (key_start),
        .key_clear (key_clear),
        .sw_dir    (sw_dir),
        .sw_preset (sw_preset),
        .digit1    (digit1),
        .digit0    (digit0),
        .blank     (blank),
        .alarm     (alarm),
        .running   (running)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [10:0] ex(
        input int d1, input int d0,
        input logic b, input logic a, input logic r
    );
        return {4'(d1), 4'(d0), b, a, r};
    endfunction

    function automatic vec_t row(
        input int act, input logic dir, input int pre,
        input int wt, input logic [10:0] e
    );
        vec_t v;
        v.act = act;
        v.dir = dir;
        v.pre = 7'(pre);
        v.wt  = wt;
        v.exp = e;
        return v;
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input logic s, input logic c);
        step(3);
        key_start = ~s;
        key_clear = ~c;
        step(4);
        key_start = 1'b1;
        key_clear = 1'b1;
    endtask

    task automatic check(input string nm, input logic [10:0] e);
        logic [10:0] got;
        got = {digit1, digit0, blank, alarm, running};
        n_cmp++;
        if (got !== e) begin
            n_bad++;
            $display("FAIL %s: got d=%0d%0d b=%b a=%b r=%b want d=%0d%0d b=%b a=%b r=%b",
                     nm, got[10:7], got[6:3], got[2], got[1], got[0],
                     e[10:7], e[6:3], e[2], e[1], e[0]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1;
        key_start = 1'b1;
        key_clear = 1'b1;
        sw_dir = 1'b0;
        sw_preset = '0;

        tbl.push_back(row(A_RST,   1, 3, 0, ex(0, 0, 0, 0, 0)));
        tbl.push_back(row(A_START, 1, 3, 0, ex(0, 0, 0, 0, 1)));
        tbl.push_back(row(A_NONE,  1, 3, 2, ex(0, 0, 0, 0, 1)));
        tbl.push_back(row(A_NONE,  1, 3, 2, ex(0, 1, 0, 0, 1)));
        tbl.push_back(row(A_NONE,  1, 3, 4, ex(0, 2, 0, 0, 1)));
        tbl.push_back(row(A_NONE,  1, 3, 4, ex(0, 3, 0, 1, 0)));
        tbl.push_back(row(A_NONE,  1, 3, 1, ex(0, 3, 0, 1, 0)));
        tbl.push_back(row(A_NONE,  1, 3, 1, ex(0, 3, 1, 1, 0)));
        tbl.push_back(row(A_NONE,  1, 3, 1, ex(0, 3, 1, 1, 0)));
        tbl.push_back(row(A_NONE,  1, 3, 1, ex(0, 3, 0, 1, 0)));
        tbl.push_back(row(A_NONE,  1, 3, 2, ex(0, 3, 1, 1, 0)));
        tbl.push_back(row(A_CLEAR, 0, 12, 0, ex(1, 2, 0, 0, 0)));
        tbl.push_back(row(A_START, 0, 12, 0, ex(1, 2, 0, 0, 1)));
        tbl.push_back(row(A_NONE,  1, 12, 4, ex(1, 1, 0, 0, 1)));
        tbl.push_back(row(A_NONE,  1, 12, 4, ex(1, 0, 0, 0, 1)));
        tbl.push_back(row(A_NONE,  0, 12, 4, ex(0, 9, 0, 0, 1)));
        tbl.push_back(row(A_NONE,  0, 12, 32, ex(0, 1, 0, 0, 1)));
        tbl.push_back(row(A_NONE,  0, 12, 3, ex(0, 1, 0, 0, 1)));
        tbl.push_back(row(A_NONE,  0, 12, 1, ex(0, 0, 0, 1, 0)));
        tbl.push_back(row(A_NONE,  0, 12, 8, ex(0, 0, 0, 1, 0)));
        tbl.push_back(row(A_CLEAR, 0, 12, 0, ex(1, 2, 0, 0, 0)));
        tbl.push_back(row(A_START, 0, 12, 5, ex(1, 1, 0, 0, 1)));
        tbl.push_back(row(A_BOTH,  0, 12, 0, ex(1, 2, 0, 0, 0)));
        tbl.push_back(row(A_NONE,  0, 12, 8, ex(1, 2, 0, 0, 0)));
        tbl.push_back(row(A_CLEAR, 0, 120, 0, ex(9, 9, 0, 0, 0)));
        tbl.push_back(row(A_START, 0, 120, 4, ex(9, 8, 0, 0, 1)));
        tbl.push_back(row(A_CLEAR, 1, 0, 0, ex(0, 0, 0, 0, 0)));
        tbl.push_back(row(A_START, 1, 0, 0, ex(0, 0, 0, 1, 0)));
        tbl.push_back(row(A_NONE,  1, 0, 3, ex(0, 0, 1, 1, 0)));
        tbl.push_back(row(A_START, 1, 0, 0, ex(0, 0, 0, 0, 0)));
        tbl.push_back(row(A_CLEAR, 1, 50, 0, ex(0, 0, 0, 0, 0)));
        tbl.push_back(row(A_START, 1, 50, 8, ex(0, 2, 0, 0, 1)));
        tbl.push_back(row(A_NONE,  1, 1, 4, ex(0, 2, 0, 1, 0)));
        tbl.push_back(row(A_START, 1, 1, 0, ex(0, 2, 0, 0, 0)));
        tbl.push_back(row(A_START, 1, 1, 0, ex(0, 2, 0, 1, 0)));

        for (int i = 0; i < tbl.size(); i++) begin
            sw_dir = tbl[i].dir;
            sw_preset = tbl[i].pre;
            case (tbl[i].act)
                A_RST: begin
                    rst = 1'b1;
                    step(2);
                    rst = 1'b0;
                end
                A_START: press(1'b1, 1'b0);
                A_CLEAR: press(1'b0, 1'b1);
                A_BOTH:  press(1'b1, 1'b1);
                default: ;
            endcase
            step(tbl[i].wt);
            check($sformatf("row%0d", i), tbl[i].exp);
        end

        // Pause keeps the partial second and resumes from it
        sw_dir = 1'b1;
        sw_preset = 7'd20;
        press(1'b0, 1'b1);
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        check("pause_entry", ex(0, 1, 0, 0, 0));
        step(20);
        check("pause_hold", ex(0, 1, 0, 0, 0));
        press(1'b1, 1'b0);
        check("resume", ex(0, 1, 0, 0, 1));
        step(1);
        check("resume_partial", ex(0, 1, 0, 0, 1));
        step(1);
        check("resume_tick", ex(0, 2, 0, 0, 1));

        // A held key gives a single press
        sw_preset = 7'd50;
        press(1'b0, 1'b1);
        step(3);
        key_start = 1'b0;
        step(4);
        check("hold_start", ex(0, 0, 0, 0, 1));
        step(12);
        check("hold_run", ex(0, 3, 0, 0, 1));
        key_start = 1'b1;

        // Reset mid-run aborts with no stray press afterwards
        step(1);
        rst = 1'b1;
        step(1);
        check("reset_midrun", ex(0, 0, 0, 0, 0));
        rst = 1'b0;
        step(6);
        check("reset_after", ex(0, 0, 0, 0, 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sec_timer_ctrl.md
# sec_timer_ctrl

Run controller for the two-digit seconds counter (0–99) that drives the HEX display pair. It turns pushbutton presses into start/pause/resume/clear commands, gates a 1 Hz tick into the counter, and stops the count at its terminal value. When the count is done it raises an alarm and flashes the display. It produces the two BCD digits plus a blank strobe; the top level passes these to the existing 7-segment decoders.

## Interface
- TICK_DIV, 50_000_000: clk cycles per counted second (≥ 2, even).
- DEBOUNCE_CYC, 500_000: cycles a key must be stable to count as a press. Used only with the debounce option enabled.
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- key_start  in  1  pushbutton, active-low, asynchronous to clk.
- key_clear  in  1  pushbutton, active-low, asynchronous to clk.
- sw_dir  in  1  count direction: 1 = up, 0 = down.
- sw_preset  in  7  target value for up-counts and load value for down-counts; values > 99 are clamped to 99.
- digit1  out  4  tens digit of the count (0–9).
- digit0  out  4  units digit of the count (0–9).
- blank  out  1  1 = display off (flash phase).
- alarm  out  1  high while in DONE.
- running  out  1  high while in RUN.

## Operation
- Key path: each key goes through a 2-flop synchronizer, then a falling-edge detector that emits a 1-cycle press pulse. Holding a key produces exactly one pulse.
- Registers:
  - value[6:0], always 0–99.
  - dir_l, the direction latched at start.
  - tick_cnt, range 0..TICK_DIV-1.
  - flash_cnt.
  - state.
- States: IDLE, RUN, PAUSE, DONE.
- Clear press, in any state:
  - state goes to IDLE;
  - value loads sw_dir ? 0 : min(sw_preset, 99);
  - tick_cnt, blank and alarm go to 0.
- Start press in IDLE:
  - dir_l latches sw_dir;
  - if the terminal condition already holds, go to DONE; otherwise go to RUN with tick_cnt = 0.
  - Terminal condition: dir_l = 0 and value = 0, or dir_l = 1 and value ≥ min(sw_preset, 99).
- Start press in RUN goes to PAUSE. Start press in PAUSE goes to RUN. tick_cnt holds its value, so a partial second resumes where it stopped.
- Start press in DONE goes to IDLE. value is kept; alarm and blank drop.
- RUN, on tick (tick_cnt = TICK_DIV-1): tick_cnt wraps to 0, and value goes ±1 according to dir_l.
  - Down-count: if the new value is 0, go to DONE.
  - Up-count: if the new value equals min(sw_preset, 99), go to DONE. The preset is sampled live; if it drops below the current value mid-run, go to DONE on the next tick without incrementing.
- value never wraps: it saturates at 0 and 99.
- DONE:
  - alarm = 1; value frozen.
  - blank toggles every TICK_DIV/2 cycles, starting at 0 on entry.
- Clear and start pressed in the same cycle: clear wins and start is dropped.
- digit1 = value / 10, digit0 = value % 10, both combinational from the value register.
- sw_dir changes during RUN or PAUSE are ignored.

## Timing
- Reset values: state IDLE, value 0, dir_l 0, tick_cnt 0, flash_cnt 0, digit1/digit0 0, blank 0, alarm 0, running 0. Reset mid-run aborts immediately with no pulse emitted.
- Key to press pulse: the pulse is high in the 3rd clk edge after the key falls. The state changes on the following edge, so the key-to-state latency is 4 cycles.
- First count after entering RUN from IDLE: value changes on edge TICK_DIV after entry.
- Digits follow value with 0 cycles of added latency.
- running and alarm are registered state decodes, valid in the same cycle as the new state.

## Configuration
- SEC_TIMER_DEBOUNCE_EN:
  - Defined: after the synchronizer, each key feeds a stability counter. The filtered level changes only after DEBOUNCE_CYC consecutive equal samples, and the edge detector runs on the filtered level. Key-to-pulse latency becomes DEBOUNCE_CYC + 3.
  - Undefined: the edge detector runs directly on the synchronized key. There is no counter and DEBOUNCE_CYC is unused.

## Structure
- Shared package:
  - state enum (IDLE, RUN, PAUSE, DONE);
  - VALUE_MAX = 99;
  - value width constant (7).
- One sub-module, key_press: synchronizer, optional debounce and falling-edge pulse; instantiated twice. The FSM, tick and flash counters live in the top.

## Test plan
All scenarios use TICK_DIV = 4 and the macro undefined.
1. Reset, then check the idle outputs → digit1 = 0, digit0 = 0, blank = 0, alarm = 0, running = 0.
2. sw_dir = 1, sw_preset = 3, start → running = 1; value steps 1, 2, 3 at 4-cycle intervals; at 3, alarm = 1 and blank toggles every 2 cycles.
3. sw_dir = 0, sw_preset = 12, clear, then start → digits 1/2 then 1/1, …, 0/0; alarm goes high at 0 and value never goes below 0.
4. Start during RUN, hold 20 cycles, start again → value frozen during PAUSE; the count resumes and the first tick arrives after the remaining tick_cnt cycles.
5. Clear and start pulsed in the same cycle during RUN → IDLE, value reloaded, running = 0.
6. Start with sw_dir = 1 and value = 0 but preset = 0 → DONE directly with no tick; then start → IDLE, alarm = 0, value = 0.
